// File: rtl/iter_fill_seq.sv
// Fill sequencer: after a start pulse, writes one constant word to each index 0..MAX_VALUE
// over a valid/ready master port. Ends with a one-cycle done pulse unless the sequence is aborted.
module iter_fill_seq #(
  parameter  int MAX_VALUE  = 15,
  parameter  int DATA_WIDTH = 16,
  localparam int ADDR_WIDTH = $clog2(MAX_VALUE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  busy,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAX_VALUE);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q,   idx_d;
  logic [DATA_WIDTH-1:0]   data_q,  data_d;
  logic                    valid_q, valid_d;
  logic                    busy_q,  busy_d;
  logic                    done_q,  done_d;
  logic                    accept;
  logic                    at_last;

  assign accept  = valid_q && m_ready;
  assign at_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          data_d  = fill_data;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // Abort wins over end-of-sequence; a beat accepted alongside it still counts.
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (accept) begin
          if (at_last) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy    = busy_q;
  assign m_valid = valid_q;
  assign m_addr  = idx_q;
  assign m_data  = data_q;
  assign done    = done_q;

endmodule

// File: tb/tb_iter_fill_seq.sv
// Randomized bench for iter_fill_seq: a transaction-level model (beats written so far,
// latched word, sequence active/finishing) predicts every output each cycle.
module tb_iter_fill_seq;
  localparam int MAXV = 15;
  localparam int DW   = 16;
  localparam int AW   = $clog2(MAXV + 1);

  logic          clk = 1'b0;
  logic          reset, start, abort, m_ready;
  logic [DW-1:0] fill_data;
  logic          busy, m_valid, done;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  logic          s_start, s_abort, s_ready;
  logic [DW-1:0] s_fill;
  logic          s_busy, s_valid, s_done;
  logic [0:0]    s_addr;
  logic [DW-1:0] s_data;

  always #5 clk = ~clk;

  iter_fill_seq #(.MAX_VALUE(MAXV), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .fill_data(fill_data),
    .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_data(m_data), .done(done)
  );

  iter_fill_seq #(.MAX_VALUE(1), .DATA_WIDTH(DW)) dut1 (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort), .fill_data(s_fill),
    .busy(s_busy), .m_valid(s_valid), .m_ready(s_ready), .m_addr(s_addr),
    .m_data(s_data), .done(s_done)
  );

  int checks = 0;
  int errors = 0;

  // Model: a sequence is "on" while beats remain; beats_done counts accepted writes.
  bit            mdl_on;
  bit            mdl_finish;
  int            beats_done;
  logic [DW-1:0] mdl_word;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_on     = 1'b0;
    mdl_finish = 1'b0;
    beats_done = 0;
    mdl_word   = '0;
  endtask

  task automatic model_step();
    if (mdl_on) begin
      if (m_ready) beats_done++;
      if (abort) mdl_on = 1'b0;
      else if (beats_done == MAXV + 1) begin
        mdl_on     = 1'b0;
        mdl_finish = 1'b1;
      end
    end else if (mdl_finish) begin
      mdl_finish = 1'b0;
    end else if (start) begin
      mdl_on     = 1'b1;
      beats_done = 0;
      mdl_word   = fill_data;
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".valid"}, 64'(m_valid), 64'(mdl_on));
    check({tag, ".busy"},  64'(busy),    64'(mdl_on || mdl_finish));
    check({tag, ".done"},  64'(done),    64'(mdl_finish));
    if (mdl_on) begin
      check({tag, ".addr"}, 64'(m_addr), 64'(beats_done));
      check({tag, ".data"}, 64'(m_data), 64'(mdl_word));
    end else if (reset) begin
      check({tag, ".addr"}, 64'(m_addr), 64'd0);
      check({tag, ".data"}, 64'(m_data), 64'd0);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare(tag);
  endtask

  task automatic run_until_idle(input string tag, input bit rand_ready, input int budget);
    int n = 0;
    while ((mdl_on || mdl_finish) && n < budget) begin
      m_ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = ($urandom_range(0, 3) == 0);
      fill_data = DW'($urandom);
      cycle(tag);
      n++;
    end
    start = 1'b0;
    check({tag, ".timeout"}, 64'(mdl_on || mdl_finish), 64'd0);
  endtask

  task automatic run_until_addr(input string tag, input int target);
    int n = 0;
    m_ready = 1'b1;
    while (mdl_on && beats_done < target && n < 50) begin
      cycle(tag);
      n++;
    end
    check({tag, ".reach"}, 64'(beats_done), 64'(target));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0; fill_data = '0;
    s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b0; s_fill = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare("reset");
    reset = 1'b0;

    // Full-throughput sequence with a fixed word.
    start = 1'b1; fill_data = 16'hA5A5; m_ready = 1'b1;
    cycle("t1_start");
    start = 1'b0;
    repeat (18) cycle("t1");

    // Random stalls and start pulses while busy.
    start = 1'b1; fill_data = 16'h1234;
    cycle("t2_start");
    start = 1'b0;
    run_until_idle("t2", 1'b1, 300);
    repeat (2) cycle("t2_idle");

    // Abort while the beat at addr 7 is stalled, then restart from addr 0.
    start = 1'b1; fill_data = 16'hBEEF;
    cycle("t3_start");
    start = 1'b0;
    run_until_addr("t3", 7);
    m_ready = 1'b0;
    cycle("t3_stall");
    abort = 1'b1;
    cycle("t3_abort");
    abort = 1'b0;
    cycle("t3_after");
    start = 1'b1; fill_data = 16'h0F0F;
    cycle("t3_restart");
    start = 1'b0;
    run_until_idle("t3_rerun", 1'b0, 40);

    // Asynchronous reset at addr 9.
    start = 1'b1; fill_data = 16'h5555;
    cycle("t5_start");
    start = 1'b0;
    run_until_addr("t5", 9);
    #2 reset = 1'b1;
    #1 model_reset();
    compare("t5_reset");
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1; fill_data = 16'h3C3C;
    cycle("t5_restart");
    start = 1'b0;
    run_until_idle("t5_rerun", 1'b1, 300);

    // Random soak including abort and start/abort collisions.
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 5) == 0);
      abort     = ($urandom_range(0, 24) == 0);
      m_ready   = ($urandom_range(0, 3) != 0);
      fill_data = DW'($urandom);
      cycle("soak");
    end
    start = 1'b0; abort = 1'b0;
    run_until_idle("soak_end", 1'b0, 40);

    // MAX_VALUE=1 instance: exactly two beats, then done.
    s_ready = 1'b1; s_start = 1'b1; s_fill = 16'hC001;
    @(posedge clk); @(negedge clk);
    s_start = 1'b0;
    check("m1.b0.valid", 64'(s_valid), 64'd1);
    check("m1.b0.addr",  64'(s_addr),  64'd0);
    check("m1.b0.data",  64'(s_data),  64'hC001);
    @(posedge clk); @(negedge clk);
    check("m1.b1.valid", 64'(s_valid), 64'd1);
    check("m1.b1.addr",  64'(s_addr),  64'd1);
    @(posedge clk); @(negedge clk);
    check("m1.done",     64'(s_done),  64'd1);
    check("m1.d.valid",  64'(s_valid), 64'd0);
    check("m1.d.busy",   64'(s_busy),  64'd1);
    @(posedge clk); @(negedge clk);
    check("m1.idle.done", 64'(s_done), 64'd0);
    check("m1.idle.busy", 64'(s_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
